// File: rtl/riot_bus_arbiter.sv
// riot_bus_arbiter
// Round-robin arbiter and bus sequencer between two on-chip requesters and the
// single RIOT (6532) register bus. One access at a time: a registered bus cycle
// with CS_n low, an optional read-latency wait, then a one-cycle ack.
//
// Ports:
//   clk, reset_n              clock shared with the RIOT, synchronous active-low reset
//   req*/we*/addr*/wdata*     requester side, held stable until ack
//   ack*/rdata*               one-cycle completion pulse and held read data
//   busy                      high while an access is in flight (BUS..DONE)
//   riot_a/riot_rs_n/riot_cs_n/riot_r_w_n/riot_din   registered RIOT bus drive
//   riot_dout                 RIOT read data, sampled on the last WAIT edge
module riot_bus_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic [6:0] riot_a,
    output logic       riot_rs_n,
    output logic       riot_cs_n,
    output logic       riot_r_w_n,
    output logic [7:0] riot_din,
    input  logic [7:0] riot_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Index of the final WAIT cycle; the counter runs 0..READ_LAT-1.
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    state_t     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_grant_q, last_grant_d;
    logic       we_q, we_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0] riot_a_q, riot_a_d;
    logic       riot_rs_n_q, riot_rs_n_d;
    logic       riot_cs_n_q, riot_cs_n_d;
    logic       riot_r_w_n_q, riot_r_w_n_d;
    logic [7:0] riot_din_q, riot_din_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       busy_q, busy_d;

    // Selected requester fields for the grant decision in IDLE.
    logic       pick_s;
    logic       sel_we_s;
    logic [7:0] sel_addr_s;
    logic [7:0] sel_wdata_s;

    // Grant selection: a lone request wins, a tie goes to the port not granted last.
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = ~last_grant_q;
        end else begin
            pick_s = req1;
        end
        sel_we_s    = pick_s ? we1    : we0;
        sel_addr_s  = pick_s ? addr1  : addr0;
        sel_wdata_s = pick_s ? wdata1 : wdata0;
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every bus signal and ack comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        wait_cnt_d   = wait_cnt_q;
        riot_a_d     = riot_a_q;
        riot_rs_n_d  = riot_rs_n_q;
        riot_din_d   = riot_din_q;
        riot_cs_n_d  = 1'b1;
        riot_r_w_n_d = 1'b1;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt_d        = pick_s;
                    we_d         = sel_we_s;
                    riot_cs_n_d  = 1'b0;
                    riot_r_w_n_d = ~sel_we_s;
                    riot_rs_n_d  = sel_addr_s[7];
                    riot_a_d     = sel_addr_s[6:0];
                    riot_din_d   = sel_wdata_s;
                    state_d      = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (we_q) begin
                    // Write completes without waiting: ack is presented in DONE.
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = 2'd0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    if (gnt_q) begin
                        rdata1_d = riot_dout;
                    end else begin
                        rdata0_d = riot_dout;
                    end
                    ack0_d     = ~gnt_q;
                    ack1_d     = gnt_q;
                    wait_cnt_d = 2'd0;
                    state_d    = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                last_grant_d = gnt_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            wait_cnt_q   <= 2'd0;
            riot_a_q     <= 7'd0;
            riot_rs_n_q  <= 1'b0;
            riot_cs_n_q  <= 1'b1;
            riot_r_w_n_q <= 1'b1;
            riot_din_q   <= 8'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= 8'd0;
            rdata1_q     <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wait_cnt_q   <= wait_cnt_d;
            riot_a_q     <= riot_a_d;
            riot_rs_n_q  <= riot_rs_n_d;
            riot_cs_n_q  <= riot_cs_n_d;
            riot_r_w_n_q <= riot_r_w_n_d;
            riot_din_q   <= riot_din_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign busy       = busy_q;
    assign riot_a     = riot_a_q;
    assign riot_rs_n  = riot_rs_n_q;
    assign riot_cs_n  = riot_cs_n_q;
    assign riot_r_w_n = riot_r_w_n_q;
    assign riot_din   = riot_din_q;

endmodule

// File: doc/riot_bus_arbiter.md
# riot_bus_arbiter

Two-port arbiter and bus sequencer sitting between on-chip requesters (e.g. the port-B LED/button sequencer and a UART-side command engine) and the single RIOT (6532) register bus. It grants one requester at a time with round-robin fairness, drives the registered RIOT bus signals for exactly one access cycle, and captures read data. It returns a one-cycle acknowledge to the requester. All logic runs on the same divided clock that clocks the RIOT.

## Interface
Parameters:
- READ_LAT, 1: cycles from the RIOT access cycle until `riot_dout` is valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; the same clock as the RIOT `CLK`.
- reset_n  in  1  synchronous, active-low reset.
- req0 / req1  in  1  access request, held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  8  bit7 drives RS_n (0 = RAM, 1 = I/O/timer); bits 6:0 drive A.
- wdata0 / wdata1  in  8  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  8  read result, held until that port's next read ack.
- busy  out  1  high whenever the FSM is not in IDLE.
- riot_a  out  7  RIOT A.
- riot_rs_n  out  1  RIOT RS_n.
- riot_cs_n  out  1  RIOT CS_n, low only during the access cycle.
- riot_r_w_n  out  1  RIOT R_W_n, 1 = read.
- riot_din  out  8  RIOT Din.
- riot_dout  in  8  RIOT Dout.

## Operation
- The FSM has four states: IDLE, BUS, WAIT, DONE.
- IDLE:
  - If any `req` is high, choose a grant, latch that port's `we`, `addr` and `wdata`, and go to BUS.
  - If no `req` is high, stay in IDLE.
- Grant rule:
  - A single request wins outright.
  - If both requests are high, the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- BUS (exactly 1 cycle):
  - `riot_cs_n`=0.
  - `riot_r_w_n`=~we.
  - `riot_rs_n`=addr[7].
  - `riot_a`=addr[6:0].
  - `riot_din`=wdata. It is driven for reads too, with value don't-care.
  - Next state: WAIT for a read, DONE for a write.
- WAIT:
  - Counts READ_LAT cycles with `riot_cs_n`=1 and `riot_r_w_n`=1.
  - On the final WAIT cycle's edge, `riot_dout` is captured into the granted port's `rdata`.
  - Next state: DONE.
- DONE:
  - The granted port's `ack`=1 for this single cycle.
  - `last_grant` is updated.
  - Next state: IDLE.
- Bus idle values, in every state except BUS:
  - `riot_cs_n`=1, `riot_r_w_n`=1.
  - `riot_a`, `riot_rs_n` and `riot_din` hold their last values.
- All RIOT-side outputs, `ack*`, `rdata*` and `busy` are registered; none is combinational from inputs.
- Requesters must keep `req`, `we`, `addr` and `wdata` stable until ack. The arbiter only samples them in IDLE.
- A request still high in the IDLE cycle after its ack is a new request. Back-to-back access is legal and is still subject to round-robin.
- A request from the non-granted port stays pending; it is never dropped.

## Timing
- Reset values (`reset_n`=0 on an edge), all taking effect at the next edge:
  - State IDLE.
  - `riot_cs_n`=1, `riot_r_w_n`=1, `riot_a`=0, `riot_rs_n`=0, `riot_din`=0.
  - `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `busy`=0.
  - `last_grant`=1, WAIT counter 0.
- Reset mid-operation:
  - The transaction is abandoned and the bus returns to idle on the next edge.
  - No ack is issued for the abandoned transaction, and no `rdata` is updated.
- Latency, counting the cycle with `req` sampled in IDLE as cycle 0:
  - Write: BUS in cycle 1, ack in cycle 2 (3 cycles).
  - Read: BUS in cycle 1, WAIT in cycles 2..1+READ_LAT, ack in cycle 2+READ_LAT.
  - At READ_LAT=1, read ack is in cycle 3.
- `rdata` for a read is valid in the ack cycle and stable afterwards.
- Sustained throughput with both ports always requesting:
  - Writes alternate 0,1,0,1 with one ack every 3 cycles.
  - No port waits more than one other transaction.
- Simultaneous requests in IDLE: the grant follows `last_grant`; the loser's request is served in the next IDLE.
- `busy` is high from BUS through DONE inclusive.

## Test plan
- After reset, port 0 writes addr 0x83, data 0x80 -> one BUS cycle with cs_n=0, r_w_n=0, rs_n=1, a=0x03, din=0x80; ack0 in cycle 2; ack1 stays 0.
- READ_LAT=1: port 1 reads 0x82 while the RIOT model returns 0x5A -> ack1 in cycle 3, rdata1=0x5A, rdata0 unchanged at 0.
- Both ports hold writes for 12 cycles -> grants alternate 0,1,0,1; exactly 4 acks; no cycle has both acks high.
- Port 0 keeps req high after its ack while port 1 also requests -> port 1 is granted next.
- READ_LAT=3 read -> ack in cycle 5, with cs_n high in cycles 2-4.
- reset_n pulled low in the BUS cycle of a read -> no ack; rdata=0; cs_n=1 on the next edge; a fresh request after release completes normally.
